// File: rtl/div_unit_pkg.sv
// Shared execute-stage constants: ALU/divider op codes, data width and divider state encoding.
package div_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 5;

  localparam logic [CTRL_W-1:0] OPDIV  = 5'd10;
  localparam logic [CTRL_W-1:0] OPDIVU = 5'd11;
  localparam logic [CTRL_W-1:0] OPREM  = 5'd12;
  localparam logic [CTRL_W-1:0] OPREMU = 5'd13;

  localparam logic [XLEN-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [CTRL_W-1:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic is_signed_op(input logic [CTRL_W-1:0] op);
    return (op == OPDIV) || (op == OPREM);
  endfunction

  function automatic logic is_rem_op(input logic [CTRL_W-1:0] op);
    return (op == OPREM) || (op == OPREMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Divider request/response bus between the execute stage and div_unit.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
);

  logic                  iStart;
  logic                  iFlush;
  logic [CTRL_W-1:0]     iControlSignal;
  logic [DATA_WIDTH-1:0] iA;
  logic [DATA_WIDTH-1:0] iB;
  logic                  oBusy;
  logic                  oDone;
  logic [DATA_WIDTH-1:0] oResult;

  modport master (
    output iStart, iFlush, iControlSignal, iA, iB,
    input  oBusy, oDone, oResult
  );

  modport slave (
    input  iStart, iFlush, iControlSignal, iA, iB,
    output oBusy, oDone, oResult
  );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per cycle,
// RISC-V divide-by-zero and signed-overflow results resolved at start.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic       iCLK,
  input  logic       iRST,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state;
  logic [CTRL_W-1:0]     op_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic                  qsign_q;
  logic                  rsign_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;

  // Start-time operand decode
  logic                  op_valid;
  logic                  op_signed;
  logic                  op_rem;
  logic                  a_neg;
  logic                  b_neg;
  logic                  div_zero;
  logic                  sgn_ovf;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH-1:0] special_res;

  assign op_valid    = is_div_op(bus.iControlSignal);
  assign op_signed   = is_signed_op(bus.iControlSignal);
  assign op_rem      = is_rem_op(bus.iControlSignal);
  assign a_neg       = op_signed & bus.iA[DATA_WIDTH-1];
  assign b_neg       = op_signed & bus.iB[DATA_WIDTH-1];
  assign a_mag       = a_neg ? (-bus.iA) : bus.iA;
  assign b_mag       = b_neg ? (-bus.iB) : bus.iB;
  assign div_zero    = (bus.iB == '0);
  assign sgn_ovf     = op_signed && (bus.iA == MIN_NEG) && (bus.iB == '1);
  assign special_res = div_zero ? (op_rem ? bus.iA : '1)
                                : (op_rem ? '0 : bus.iA);

  // One restoring step: the shifted partial remainder needs one extra bit before the subtract
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   trial;
  logic                  fits;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  assign rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign fits    = ~trial[DATA_WIDTH];
  assign quo_fix = qsign_q ? (-quo_q) : quo_q;
  assign rem_fix = rsign_q ? (-rem_q) : rem_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= DATA_WIDTH'(ZERO);
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart && !bus.iFlush && op_valid) begin
            op_q <= bus.iControlSignal;
            if (div_zero || sgn_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              qsign_q <= a_neg ^ b_neg;
              rsign_q <= a_neg;
              cnt_q   <= CNT_LAST;
              busy_q  <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.iFlush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            rem_q <= fits ? trial[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], fits};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.iFlush) begin
            state <= IDLE;
          end else begin
            result_q <= is_rem_op(op_q) ? rem_fix : quo_fix;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oResult = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RISC-V corner cases plus a random sweep
// against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned W        = 32;
  localparam int unsigned NORM_LAT = W + 2;
  localparam int          BUDGET   = 60;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_unit_if #(.DATA_WIDTH(W)) bus ();

  div_unit #(.DATA_WIDTH(W)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed with 64-bit integer arithmetic
  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 0) return (op == OPREM || op == OPREMU) ? a : 32'hFFFF_FFFF;
    case (op)
      OPDIV:   return 32'(sa / sb);
      OPREM:   return 32'(sa % sb);
      OPDIVU:  return 32'(ua / ub);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (b == 0) return 1;
    if ((op == OPDIV || op == OPREM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NORM_LAT;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op in cycle 0; optionally re-start/flush/reset in a later cycle.
  // lat is the cycle oDone was seen (-1 if never), busy_cnt the cycles with oBusy high.
  task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int restart_at, input int flush_at, input int rst_at,
                     output logic [W-1:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.iStart         = 1'b1;
    bus.iFlush         = 1'b0;
    bus.iControlSignal = op;
    bus.iA             = a;
    bus.iB             = b;
    lat      = -1;
    busy_cnt = 0;
    res      = '0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (bus.oBusy) busy_cnt++;
      bus.iStart         = (cyc == restart_at);
      bus.iFlush         = (cyc == flush_at);
      rst                = (cyc == rst_at);
      bus.iControlSignal = (cyc == restart_at) ? OPDIVU : op;
      bus.iA             = 32'($urandom);
      bus.iB             = 32'($urandom_range(1, 9));
      if (bus.oDone) begin
        lat = cyc;
        res = bus.oResult;
        break;
      end
    end
    bus.iStart = 1'b0;
    bus.iFlush = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    logic [W-1:0] res;
    int           lat;
    int           bc;
    run(op, a, b, 0, 0, 0, res, lat, bc);
    check({tag, "_res"}, res, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   op;
    int           lat;
    int           bc;

    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    bus.iStart         = 1'b0;
    bus.iFlush         = 1'b0;
    bus.iControlSignal = '0;
    bus.iA             = '0;
    bus.iB             = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_done", 32'(bus.oDone), 32'd0);
    check("rst_result", bus.oResult, 32'd0);
    rst = 1'b0;

    directed("div_neg", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_neg", OPREM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("divu", OPDIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
    directed("remu", OPREMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34);
    directed("div_by0", OPDIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("rem_by0", OPREM, 32'd5, 32'd0, 32'h0000_0005, 1);
    directed("div_ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", OPREM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    directed("divu_ovf", OPDIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);

    // Unknown op code with start: no response
    run(5'd0, 32'd9, 32'd3, 0, 0, 0, res, lat, bc);
    check("badop_lat", 32'(lat), 32'hFFFF_FFFF);
    check("badop_busy", 32'(bc), 32'd0);

    // Second start mid-operation is ignored
    run(OPDIV, 32'd1000, 32'd7, 10, 0, 0, res, lat, bc);
    check("restart_res", res, 32'd142);
    check("restart_lat", 32'(lat), 32'd34);

    // Flush mid-operation: no done, result retained, then a fresh op works
    run(OPDIV, 32'd5000, 32'd3, 0, 15, 0, res, lat, bc);
    check("flush_lat", 32'(lat), 32'hFFFF_FFFF);
    check("flush_busy", 32'(bc), 32'd15);
    check("flush_hold", bus.oResult, 32'd142);
    directed("after_flush", OPDIV, 32'd100, 32'd7, 32'd14, 34);

    // Reset mid-operation: no done, outputs cleared
    run(OPREMU, 32'd77, 32'd5, 0, 0, 20, res, lat, bc);
    check("rst_mid_lat", 32'(lat), 32'hFFFF_FFFF);
    check("rst_mid_busy", 32'(bus.oBusy), 32'd0);
    check("rst_mid_result", bus.oResult, 32'd0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OPDIV;
        1:       op = OPDIVU;
        2:       op = OPREM;
        default: op = OPREMU;
      endcase
      a = pick_operand();
      b = pick_operand();
      run(op, a, b, 0, 0, 0, res, lat, bc);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), res, ref_result(op, a, b));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_latency(op, a, b)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the execute stage.
- Sits beside the combinational ALU and takes the same operand buses and 5-bit control code.
- Its result feeds the same execute-result mux as the ALU output; the hazard unit stalls the pipeline while oBusy is high.
- It removes the single-cycle "/" and "%" path from the critical timing path.

Parameters:
- DATA_WIDTH, 32: operand/result width. Iteration count equals DATA_WIDTH.

Ports:
- iCLK  input  1  clock
- iRST  input  1  synchronous active-high reset
- iStart  input  1  start request; sampled only in IDLE
- iFlush  input  1  abort the current operation (pipeline flush)
- iControlSignal  input  5  OPDIV / OPDIVU / OPREM / OPREMU; other codes ignored
- iA  input  DATA_WIDTH  dividend
- iB  input  DATA_WIDTH  divisor
- oBusy  output  1  high from the cycle after start is accepted until oDone
- oDone  output  1  one-cycle pulse; oResult valid in that cycle
- oResult  output  DATA_WIDTH  quotient or remainder

Behaviour:
- Single clock iCLK; reset iRST is synchronous and active-high.
- Reset: state IDLE, oBusy=0, oDone=0, oResult=0, internal registers cleared.
- iRST mid-operation returns the unit to IDLE on the next edge; no oDone is produced.
- States:
  - IDLE → CALC on iStart with a valid op code, normal case.
  - IDLE → DONE on iStart with a valid op code, special case.
  - CALC → FIX after DATA_WIDTH iterations.
  - FIX → DONE.
  - DONE → IDLE.
- iStart with any other op code is ignored; the unit stays IDLE.
- Start capture:
  - Latch the op code.
  - For signed ops, latch the magnitudes |iA| and |iB|, the quotient sign (sign(iA) XOR sign(iB)) and the remainder sign (sign(iA)).
  - For unsigned ops, latch raw operands with signs 0.
  - Load the iteration counter with DATA_WIDTH-1.
- CALC, one iteration per cycle:
  - {rem,quo} shifted left 1.
  - Trial = rem - divisor, computed at DATA_WIDTH+1 bits.
  - If non-negative: rem = trial and quo LSB = 1; else quo LSB = 0.
  - Counter decrements; leave CALC when counter = 0 after that iteration.
- FIX: negate quo if the quotient sign is set, negate rem if the remainder sign is set, then select quo for DIV/DIVU and rem for REM/REMU into oResult.
- DONE: oDone=1 for exactly one cycle and oBusy=0 in that cycle.
- oResult holds its value until the next DONE or reset.
- Normal latency: iStart high in cycle 0 → oDone in cycle DATA_WIDTH+2 (cycle 34). oBusy is high in cycles 1..33.
- Special cases (RISC-V spec), decided at start and routed straight to DONE, so oDone appears in cycle 1:
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → iA.
  - Signed overflow, iA = 0x80000000 and iB = 0xFFFFFFFF, DIV: → 0x80000000. REM: → 0.
- Overflow with DIVU/REMU is not special and takes the normal path.
- iStart while not IDLE: ignored, with no effect on the operation in flight.
- iFlush:
  - In CALC, FIX or DONE: next state IDLE, no oDone pulse, oResult unchanged.
  - In IDLE: also suppresses a same-cycle iStart.
- iFlush and iRST together: reset takes precedence (the outcome is identical).
- Operands are not required to be held after the start cycle.

Decomposition:
- Shared package (also used by ALU and the ALU control decoder):
  - Op-code constants OPDIV, OPDIVU, OPREM, OPREMU.
  - ZERO constant.
  - div state encoding constants (IDLE, CALC, FIX, DONE).
- No sub-module is needed. Datapath and FSM fit in a single module of about 180 lines.
- The ALU keeps "/" and "%" only under a separate define for comparison in simulation.

Test Plan:
- DIV A=0xFFFFFFF9 (-7), B=2 → oResult 0xFFFFFFFD (-3), oDone in cycle 34. Same operands with REM → 0xFFFFFFFF (-1).
- DIVU A=0xFFFFFFF9, B=2 → 0x7FFFFFFC. REMU with the same operands → 0x00000001.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 0x00000005. Both with oDone in cycle 1 and oBusy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both in cycle 1.
- DIVU with the same operands → 0x00000000 with normal latency of 34 cycles.
- iStart pulsed again in cycle 10 with different operands → ignored; the first result arrives unchanged in cycle 34.
- iFlush in cycle 15 → IDLE next cycle, no oDone, oResult retains its previous value; a new DIV 100/7 then yields 14.
- iRST in cycle 20 → all outputs 0 next cycle. Random signed/unsigned sweep (including 0, 1, -1, 0x80000000) matches the reference model.
